rs: RTL and testbench
=====================

# rs

Reservation station between allocation and execution. Accepts dispatched micro-ops (`t_uinstr_disp`) from allocation in stage RS1 and holds them until both sources are no longer ROB-pending. Selects the oldest ready entry each cycle and issues it into a registered output stage RS2. Applies backpressure to allocation through `rs_stall_rs0`. One instance is used per dispatch port (EX and MM).

## Interface

Parameters:
- `NUM_ENTRIES`, default 8: number of RS entries; must be at least 4.
- `ENTRY_IDX_W`, default `$clog2(NUM_ENTRIES)`: width of an entry index.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; asserting it (0) clears all state immediately.
- `disp_valid_rs1`  in  1  dispatch valid from allocation.
- `disp_rs1`  in  `t_uinstr_disp`  dispatched micro-op: uinstr, robid, src1/src2 `rob_pdg` and `robid`.
- `rs_stall_rs0`  out  1  backpressure to allocation; allocation must not launch a dispatch in the cycle after this is high.
- `wb_valid_ex`  in  1  result broadcast valid.
- `wb_robid_ex`  in  `t_rob_id`  ROB id being written back.
- `iss_stall_rs2`  in  1  downstream cannot accept; hold the RS2 output.
- `iss_valid_rs2`  out  1  issue valid (registered).
- `iss_rs2`  out  `t_uinstr_disp`  issued micro-op (registered).

## Operation

- Per-entry state:
  - `valid`
  - `t_uinstr_disp` payload
  - age-matrix row of `NUM_ENTRIES` bits; bit j set means entry j is older.
- **Allocate.** On `disp_valid_rs1`, write the lowest-index free entry.
  - Set its age row to the current valid vector, excluding any entry being issued this cycle.
  - Clear column i in all rows.
- **Wakeup.** When `wb_valid_ex` is high, for every valid entry and for the incoming dispatch:
  - if `srcN_rob_pdg` is set and `srcN_robid == wb_robid_ex`, clear `srcN_rob_pdg`.
  - The incoming-dispatch case covers a broadcast in the same cycle as allocation; that wakeup must not be lost.
- **Ready.** An entry is ready when `valid & ~src1_rob_pdg & ~src2_rob_pdg`, evaluated on registered state.
  - A wakeup in cycle N makes the entry eligible in cycle N+1.
- **Select.** The oldest ready entry wins: the ready entry with no ready older entry according to its age row. At most one entry is selected per cycle.
- **Issue.**
  - When `iss_stall_rs2` is 0, load the RS2 register with the selected entry and set `iss_valid_rs2` to whether any entry was ready. The selected entry's `valid` is cleared on the same edge.
  - When `iss_stall_rs2` is 1, hold the RS2 register, perform no select and deallocate nothing.
- **Stall.** `rs_stall_rs0` = (number of free entries ≤ 1), computed from registered valid bits only. This reserves one slot for a dispatch already in flight from RS0 to RS1.
- **Full.** A dispatch arriving with zero free entries is a protocol error. Under `ASSERT` this fires an assertion; the RTL drops the dispatch.
- **Simultaneous events.**
  - Allocate and issue of a different entry in the same cycle are both performed.
  - A freed entry is not reusable until the next cycle.
- **Reset.** Asserting `reset` mid-operation clears all entries and outputs asynchronously. The first dispatch after release is accepted normally.

## Timing

- Reset values:
  - `iss_valid_rs2` = 0
  - `iss_rs2` = '0
  - `rs_stall_rs0` = 0
  - all entry valids = 0
- Latency:
  - Dispatch with both sources non-pending in cycle N → entry valid in N+1 → `iss_valid_rs2` high in N+2.
  - Pending source woken by `wb_valid_ex` in cycle M, with the entry already resident → `iss_valid_rs2` in M+2.
- Throughput: one issue per cycle.
- `rs_stall_rs0` reflects state after the previous edge. It rises in the cycle after occupancy reaches `NUM_ENTRIES-1`.

## Test plan

- Reset, then dispatch robid 3 with no pending sources in cycle 1 → `iss_valid_rs2` = 1 with `iss_rs2.robid` = 3 in cycle 3, and RS is empty afterwards.
- Dispatch robid 5 (src1 pending on robid 2), then robid 6 (ready) → robid 6 issues first. Broadcast `wb_robid_ex` = 2 in cycle 4 → robid 5 issues in cycle 6.
- Three ready dispatches robid 7, 8, 9 in consecutive cycles → issued in order 7, 8, 9 on consecutive cycles. Holding `iss_stall_rs2` = 1 for 2 cycles freezes `iss_rs2` = 7 and delays 8 and 9 by 2 cycles.
- Fill `NUM_ENTRIES` = 8 with pending entries → `rs_stall_rs0` goes high after 7 allocations; the 8th, in-flight, dispatch is accepted. Wake one entry → it issues and `rs_stall_rs0` deasserts the following cycle.
- Dispatch robid 4 with src2 pending on robid 1 in the same cycle as `wb_robid_ex` = 1 → robid 4 issues 2 cycles later with no missed wakeup.
- Assert `reset` = 0 mid-stream with 5 entries occupied → `iss_valid_rs2` drops to 0 immediately. After release, a new dispatch issues with 2-cycle latency.

Source files
------------

// File: rtl/rs.sv
// Reservation station: holds dispatched micro-ops until both sources are no
// longer ROB-pending, picks the oldest ready entry through an age matrix and
// issues it into a registered RS2 stage. Shared types live in rs_pkg.

package rs_pkg;
    typedef logic [5:0] t_rob_id;

    typedef struct packed {
        logic [15:0] uinstr;
        t_rob_id     robid;
        logic        src1_rob_pdg;
        t_rob_id     src1_robid;
        logic        src2_rob_pdg;
        t_rob_id     src2_robid;
    } t_uinstr_disp;
endpackage

module rs
    import rs_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int ENTRY_IDX_W = $clog2(NUM_ENTRIES)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         disp_valid_rs1,
    input  t_uinstr_disp disp_rs1,
    output logic         rs_stall_rs0,
    input  logic         wb_valid_ex,
    input  t_rob_id      wb_robid_ex,
    input  logic         iss_stall_rs2,
    output logic         iss_valid_rs2,
    output t_uinstr_disp iss_rs2
);

    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic [NUM_ENTRIES-1:0] r_valid;
    t_uinstr_disp           r_entry [NUM_ENTRIES];
    // Row i, bit j set: entry j is older than entry i.
    logic [NUM_ENTRIES-1:0] r_age   [NUM_ENTRIES];

    logic                   r_iss_valid;
    t_uinstr_disp           r_iss;

    logic [NUM_ENTRIES-1:0] w_ready;
    logic [NUM_ENTRIES-1:0] w_sel_oh;
    logic [NUM_ENTRIES-1:0] w_iss_oh;
    logic [NUM_ENTRIES-1:0] w_free;
    logic                   w_any_ready;
    logic                   w_issue;
    logic                   w_has_free;
    logic                   w_alloc;
    logic [ENTRY_IDX_W-1:0] w_alloc_idx;
    logic [CNT_W-1:0]       w_free_cnt;
    t_uinstr_disp           w_sel_entry;
    t_uinstr_disp           w_disp_woken;

    // Ready and oldest-ready select, both from registered state only.
    generate
        for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_sel
            assign w_ready[gi]  = r_valid[gi] & ~r_entry[gi].src1_rob_pdg
                                              & ~r_entry[gi].src2_rob_pdg;
            assign w_sel_oh[gi] = w_ready[gi] & ~|(r_age[gi] & w_ready);
        end
    endgenerate

    assign w_any_ready = |w_ready;
    assign w_issue     = ~iss_stall_rs2 & w_any_ready;
    assign w_iss_oh    = w_issue ? w_sel_oh : '0;
    assign w_free      = ~r_valid;
    assign w_has_free  = |w_free;
    assign w_alloc     = disp_valid_rs1 & w_has_free;

    // Lowest free slot and free count; a slot freed this cycle is not yet
    // visible here, so it cannot be reused until the next cycle.
    always_comb begin
        w_alloc_idx = '0;
        w_free_cnt  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_alloc_idx = ENTRY_IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_free_cnt = w_free_cnt + CNT_W'(w_free[i]);
        end
    end

    // One slot stays reserved for a dispatch already in flight from RS0.
    assign rs_stall_rs0 = (w_free_cnt <= CNT_W'(1));

    // One-hot mux of the selected entry payload.
    always_comb begin
        w_sel_entry = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (w_sel_oh[i]) begin
                w_sel_entry = r_entry[i];
            end
        end
    end

    // Apply a same-cycle broadcast to the incoming dispatch so it is not lost.
    always_comb begin
        w_disp_woken = disp_rs1;
        if (wb_valid_ex && disp_rs1.src1_rob_pdg && (disp_rs1.src1_robid == wb_robid_ex)) begin
            w_disp_woken.src1_rob_pdg = 1'b0;
        end
        if (wb_valid_ex && disp_rs1.src2_rob_pdg && (disp_rs1.src2_robid == wb_robid_ex)) begin
            w_disp_woken.src2_rob_pdg = 1'b0;
        end
    end

    // Entry array: allocate, wake up, deallocate on issue, maintain age matrix.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_entry[i] <= '0;
                r_age[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (w_alloc && (w_alloc_idx == ENTRY_IDX_W'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_entry[i] <= w_disp_woken;
                    // Everything still resident after this edge is older.
                    r_age[i]   <= r_valid & ~w_iss_oh;
                end else begin
                    if (w_iss_oh[i]) begin
                        r_valid[i] <= 1'b0;
                    end
                    if (wb_valid_ex && r_valid[i]) begin
                        if (r_entry[i].src1_rob_pdg && (r_entry[i].src1_robid == wb_robid_ex)) begin
                            r_entry[i].src1_rob_pdg <= 1'b0;
                        end
                        if (r_entry[i].src2_rob_pdg && (r_entry[i].src2_robid == wb_robid_ex)) begin
                            r_entry[i].src2_rob_pdg <= 1'b0;
                        end
                    end
                    // The new entry is younger than every other one.
                    if (w_alloc) begin
                        r_age[i][w_alloc_idx] <= 1'b0;
                    end
                end
            end
        end
    end

    // RS2 output register; held while downstream stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_iss_valid <= 1'b0;
            r_iss       <= '0;
        end else if (!iss_stall_rs2) begin
            r_iss_valid <= w_any_ready;
            r_iss       <= w_sel_entry;
        end
    end

    assign iss_valid_rs2 = r_iss_valid;
    assign iss_rs2       = r_iss;

`ifdef ASSERT
    // A dispatch into a full station breaks the stall protocol and is dropped.
    always @(posedge clk) begin
        if (reset) begin
            assert (!(disp_valid_rs1 && !w_has_free))
                else $error("rs: dispatch arrived with no free entry");
        end
    end
`endif

endmodule

// File: tb/tb_rs.sv
// Bench for rs: directed scenarios followed by randomized traffic, all
// checked against an in-order queue model of the station.

module tb_rs;
    import rs_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         disp_valid_rs1 = 1'b0;
    t_uinstr_disp disp_rs1 = '0;
    logic         rs_stall_rs0;
    logic         wb_valid_ex = 1'b0;
    t_rob_id      wb_robid_ex = '0;
    logic         iss_stall_rs2 = 1'b0;
    logic         iss_valid_rs2;
    t_uinstr_disp iss_rs2;

    always #5 clk = ~clk;

    rs #(.NUM_ENTRIES(N)) dut (
        .clk            (clk),
        .reset          (reset),
        .disp_valid_rs1 (disp_valid_rs1),
        .disp_rs1       (disp_rs1),
        .rs_stall_rs0   (rs_stall_rs0),
        .wb_valid_ex    (wb_valid_ex),
        .wb_robid_ex    (wb_robid_ex),
        .iss_stall_rs2  (iss_stall_rs2),
        .iss_valid_rs2  (iss_valid_rs2),
        .iss_rs2        (iss_rs2)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: resident micro-ops kept in arrival order (front = oldest).
    t_uinstr_disp mq[$];
    logic         m_iv    = 1'b0;
    t_uinstr_disp m_iss   = '0;
    logic         m_stall = 1'b0;

    function automatic t_uinstr_disp wake(input t_uinstr_disp u);
        t_uinstr_disp r;
        r = u;
        if (wb_valid_ex && r.src1_rob_pdg && r.src1_robid == wb_robid_ex) r.src1_rob_pdg = 1'b0;
        if (wb_valid_ex && r.src2_rob_pdg && r.src2_robid == wb_robid_ex) r.src2_rob_pdg = 1'b0;
        return r;
    endfunction

    task automatic model_clear();
        mq.delete();
        m_iv    = 1'b0;
        m_iss   = '0;
        m_stall = 1'b0;
    endtask

    task automatic model_step();
        int n_before;
        int pick;
        if (!reset) begin
            model_clear();
        end else begin
            n_before = mq.size();
            if (!iss_stall_rs2) begin
                pick = -1;
                for (int k = 0; k < mq.size(); k++) begin
                    if (pick < 0 && !mq[k].src1_rob_pdg && !mq[k].src2_rob_pdg) pick = k;
                end
                if (pick >= 0) begin
                    m_iv  = 1'b1;
                    m_iss = mq[pick];
                    mq.delete(pick);
                end else begin
                    m_iv  = 1'b0;
                    m_iss = '0;
                end
            end
            for (int k = 0; k < mq.size(); k++) mq[k] = wake(mq[k]);
            if (disp_valid_rs1 && n_before < N) mq.push_back(wake(disp_rs1));
            m_stall = ((N - mq.size()) <= 1);
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("iss_valid", 64'(iss_valid_rs2), 64'(m_iv));
        if (m_iv) chk("iss_payload", 64'(iss_rs2), 64'(m_iss));
        chk("rs_stall", 64'(rs_stall_rs0), 64'(m_stall));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    function automatic t_uinstr_disp mk(input logic [5:0] robid, input logic p1, input logic [5:0] r1,
                                        input logic p2, input logic [5:0] r2);
        t_uinstr_disp u;
        u.uinstr       = 16'($urandom);
        u.robid        = robid;
        u.src1_rob_pdg = p1;
        u.src1_robid   = r1;
        u.src2_rob_pdg = p2;
        u.src2_robid   = r2;
        return u;
    endfunction

    task automatic disp(input t_uinstr_disp u);
        disp_valid_rs1 = 1'b1;
        disp_rs1       = u;
    endtask

    task automatic idle();
        disp_valid_rs1 = 1'b0;
        disp_rs1       = '0;
        wb_valid_ex    = 1'b0;
        iss_stall_rs2  = 1'b0;
    endtask

    task automatic wb(input logic [5:0] id);
        wb_valid_ex = 1'b1;
        wb_robid_ex = id;
    endtask

    initial begin
        logic stall_prev;
        logic allow;

        // Reset state.
        #2;
        chk("rst_iss_valid", 64'(iss_valid_rs2), 64'd0);
        chk("rst_iss_rs2", 64'(iss_rs2), 64'd0);
        chk("rst_stall", 64'(rs_stall_rs0), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Single ready dispatch: two-cycle latency, then empty.
        disp(mk(6'd3, 1'b0, 6'd0, 1'b0, 6'd0));
        cycle();
        idle();
        cycle();
        chk("t1_valid", 64'(iss_valid_rs2), 64'd1);
        chk("t1_robid", 64'(iss_rs2.robid), 64'd3);
        cycle();
        chk("t1_empty", 64'(iss_valid_rs2), 64'd0);

        // Pending entry overtaken by a younger ready one, then woken.
        disp(mk(6'd5, 1'b1, 6'd2, 1'b0, 6'd0));
        cycle();
        disp(mk(6'd6, 1'b0, 6'd0, 1'b0, 6'd0));
        cycle();
        idle();
        cycle();
        chk("t2_first_valid", 64'(iss_valid_rs2), 64'd1);
        chk("t2_first_robid", 64'(iss_rs2.robid), 64'd6);
        wb(6'd2);
        cycle();
        idle();
        chk("t2_gap", 64'(iss_valid_rs2), 64'd0);
        cycle();
        chk("t2_second_valid", 64'(iss_valid_rs2), 64'd1);
        chk("t2_second_robid", 64'(iss_rs2.robid), 64'd5);
        cycle();

        // Back-to-back issue with a two-cycle downstream stall.
        disp(mk(6'd7, 1'b0, 6'd0, 1'b0, 6'd0));
        cycle();
        disp(mk(6'd8, 1'b0, 6'd0, 1'b0, 6'd0));
        cycle();
        chk("t3_7", 64'(iss_rs2.robid), 64'd7);
        disp(mk(6'd9, 1'b0, 6'd0, 1'b0, 6'd0));
        iss_stall_rs2 = 1'b1;
        cycle();
        chk("t3_hold1", 64'(iss_rs2.robid), 64'd7);
        disp_valid_rs1 = 1'b0;
        cycle();
        chk("t3_hold2", 64'(iss_rs2.robid), 64'd7);
        chk("t3_hold2_valid", 64'(iss_valid_rs2), 64'd1);
        idle();
        cycle();
        chk("t3_8", 64'(iss_rs2.robid), 64'd8);
        cycle();
        chk("t3_9", 64'(iss_rs2.robid), 64'd9);
        cycle();
        chk("t3_empty", 64'(iss_valid_rs2), 64'd0);

        // Dispatch and matching broadcast in the same cycle.
        disp(mk(6'd4, 1'b0, 6'd0, 1'b1, 6'd1));
        wb(6'd1);
        cycle();
        idle();
        cycle();
        chk("t5_valid", 64'(iss_valid_rs2), 64'd1);
        chk("t5_robid", 64'(iss_rs2.robid), 64'd4);
        cycle();

        // Fill with pending entries; entries 3 and 7 share a source.
        for (int k = 0; k < N; k++) begin
            if (k == 6) chk("t4_stall_lo", 64'(rs_stall_rs0), 64'd0);
            if (k == 7) chk("t4_stall_hi", 64'(rs_stall_rs0), 64'd1);
            disp(mk(6'(32 + k), 1'b1, (k == 7) ? 6'd19 : 6'(16 + k), 1'b0, 6'd0));
            cycle();
        end
        idle();
        chk("t4_full_stall", 64'(rs_stall_rs0), 64'd1);
        wb(6'd19);
        cycle();
        idle();
        cycle();
        chk("t4_iss_a", 64'(iss_rs2.robid), 64'd35);
        chk("t4_stall_one_free", 64'(rs_stall_rs0), 64'd1);
        cycle();
        chk("t4_iss_b", 64'(iss_rs2.robid), 64'd39);
        chk("t4_stall_release", 64'(rs_stall_rs0), 64'd0);
        wb(6'd16);
        cycle();
        idle();
        cycle();
        chk("t6_pre_valid", 64'(iss_valid_rs2), 64'd1);

        // Asynchronous reset mid-stream with five entries resident.
        #3;
        reset = 1'b0;
        #1;
        model_clear();
        chk("t6_rst_valid", 64'(iss_valid_rs2), 64'd0);
        chk("t6_rst_stall", 64'(rs_stall_rs0), 64'd0);
        cycle();
        reset = 1'b1;
        disp(mk(6'd10, 1'b0, 6'd0, 1'b0, 6'd0));
        cycle();
        idle();
        cycle();
        chk("t6_post_valid", 64'(iss_valid_rs2), 64'd1);
        chk("t6_post_robid", 64'(iss_rs2.robid), 64'd10);
        wb(6'd17);
        cycle();
        idle();
        cycle();
        chk("t6_flushed", 64'(iss_valid_rs2), 64'd0);

        // Randomized traffic honouring the one-cycle stall protocol.
        stall_prev = m_stall;
        for (int c = 0; c < 600; c++) begin
            allow      = !stall_prev;
            stall_prev = m_stall;
            idle();
            if (allow && ($urandom_range(0, 2) != 0)) begin
                disp(mk(6'($urandom), ($urandom_range(0, 2) == 0), 6'($urandom_range(0, 15)),
                        ($urandom_range(0, 2) == 0), 6'($urandom_range(0, 15))));
            end
            if ($urandom_range(0, 1) == 1) wb(6'($urandom_range(0, 15)));
            iss_stall_rs2 = ($urandom_range(0, 4) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
